// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX serializer between several
// byte-packet requesters, holding each grant for a whole packet.
module uart_tx_arbiter #(
   parameter int N_REQ       = 2,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    tx_valid,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_ready,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic                    timeout_pulse
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SUM_W = PTR_W + 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0    = N_REQ'(1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [N_REQ-1:0] grant_next;
   logic [PTR_W-1:0] rr_ptr, rr_ptr_next;
   logic [CNT_W-1:0] stall_cnt, stall_cnt_next;
   logic             timeout_next;
   logic [PTR_W-1:0] owner_idx, owner_inc, pick_idx;
   logic             pick_found;
   logic             xfer;

   always_comb begin
      owner_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) owner_idx = PTR_W'(i);
      end
   end

   assign owner_inc = (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);

   // Handshake: a byte moves when valid and ready are both high on a rising
   // edge; the owner's req_ready mirrors tx_ready, every other ready stays low.
   assign tx_valid  = |(req_valid & grant);
   assign req_ready = grant & {N_REQ{tx_ready}};
   assign xfer      = tx_valid & tx_ready;
   assign busy      = (state == LOCKED);

   always_comb begin
      tx_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         tx_data = tx_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
      end
   end

   // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      logic [SUM_W-1:0] sum;
      logic [PTR_W-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      sum        = '0;
      cand       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
         cand = sum[PTR_W-1:0];
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next     = state;
      grant_next     = grant;
      rr_ptr_next    = rr_ptr;
      stall_cnt_next = stall_cnt;
      timeout_next   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_next     = LOCKED;
               grant_next     = ONE_HOT0 << pick_idx;
               stall_cnt_next = '0;
            end
         end
         LOCKED: begin
            if (xfer) begin
               stall_cnt_next = '0;
               if (req_last[owner_idx]) begin
                  state_next  = IDLE;
                  grant_next  = '0;
                  rr_ptr_next = owner_inc;
               end
            end else if (stall_cnt == STALL_LIMIT) begin
               // A transfer on this same cycle would have taken the branch above.
               state_next     = IDLE;
               grant_next     = '0;
               rr_ptr_next    = owner_inc;
               stall_cnt_next = '0;
               timeout_next   = 1'b1;
            end else begin
               stall_cnt_next = stall_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= '0;
         rr_ptr        <= '0;
         stall_cnt     <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         state         <= state_next;
         grant         <= grant_next;
         rr_ptr        <= rr_ptr_next;
         stall_cnt     <= stall_cnt_next;
         timeout_pulse <= timeout_next;
      end
   end

   grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   busy_matches_grant_a: assert property (@(posedge clk) disable iff (rst) busy == (grant != '0));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed packet sequences and a
// randomized run against a cycle-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

   localparam int N_REQ       = 2;
   localparam int DATA_W      = 8;
   localparam int TIMEOUT_CYC = 16;
   localparam int NV          = 12;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        req_ready;
   logic                    tx_valid;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_ready;
   logic [N_REQ-1:0]        grant;
   logic                    busy;
   logic                    timeout_pulse;

   uart_tx_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [1:0] v;
      logic [1:0] l;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       tr;
      logic [1:0] eg;
      logic       etv;
      logic [7:0] ed;
      logic [1:0] erdy;
      logic       ebusy;
      logic       eto;
   } vec_t;

   vec_t vecs[NV];
   vec_t cur;
   int   vidx;

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 when nobody holds the UART), pointer,
   // count of consecutive stalled owned cycles, and the pending pulse.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_stall = 0;
   bit m_pulse = 1'b0;

   bit vec_on = 1'b0;
   bit sb_on  = 1'b0;
   bit src_on = 1'b0;

   logic [8:0] exp_q[$];
   logic [8:0] src_q0[$];
   logic [8:0] src_q1[$];

   logic       xfer_seen, xfer_src, xfer_last;
   logic [1:0] snap_grant, snap_ready;
   logic       snap_pulse, snap_txv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_compare();
      logic [1:0] eg;
      logic       etv;
      eg  = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
      etv = (m_owner >= 0) && req_valid[m_owner];
      check("model_grant", grant, eg);
      check("model_busy", busy, m_owner >= 0);
      check("model_timeout_pulse", timeout_pulse, m_pulse);
      check("model_tx_valid", tx_valid, etv);
      check("model_req_ready", req_ready, (m_owner >= 0 && tx_ready) ? eg : 2'b00);
      if (etv) check("model_tx_data", tx_data, req_data[m_owner*DATA_W +: DATA_W]);
   endtask

   task automatic model_step();
      bit found;
      int idx;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_stall = 0;
         m_pulse = 1'b0;
      end else begin
         m_pulse = 1'b0;
         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
               idx = (m_ptr + k) % N_REQ;
               if (!found && req_valid[idx]) begin
                  found   = 1'b1;
                  m_owner = idx;
                  m_stall = 0;
               end
            end
         end else if (req_valid[m_owner] && tx_ready) begin
            m_stall = 0;
            if (req_last[m_owner]) begin
               m_ptr   = (m_owner + 1) % N_REQ;
               m_owner = -1;
            end
         end else begin
            m_stall++;
            if (m_stall == TIMEOUT_CYC) begin
               m_pulse = 1'b1;
               m_ptr   = (m_owner + 1) % N_REQ;
               m_owner = -1;
               m_stall = 0;
            end
         end
      end
   endtask

   task automatic vec_compare();
      check($sformatf("vec%0d_grant", vidx), grant, cur.eg);
      check($sformatf("vec%0d_busy", vidx), busy, cur.ebusy);
      check($sformatf("vec%0d_timeout_pulse", vidx), timeout_pulse, cur.eto);
      check($sformatf("vec%0d_tx_valid", vidx), tx_valid, cur.etv);
      check($sformatf("vec%0d_req_ready", vidx), req_ready, cur.erdy);
      if (cur.etv) check($sformatf("vec%0d_tx_data", vidx), tx_data, cur.ed);
   endtask

   task automatic drive_src(input logic [1:0] en);
      req_valid[0]   = en[0] && (src_q0.size() > 0);
      req_last[0]    = (src_q0.size() > 0) ? src_q0[0][8] : 1'b0;
      req_data[7:0]  = (src_q0.size() > 0) ? src_q0[0][7:0] : 8'h00;
      req_valid[1]   = en[1] && (src_q1.size() > 0);
      req_last[1]    = (src_q1.size() > 0) ? src_q1[0][8] : 1'b0;
      req_data[15:8] = (src_q1.size() > 0) ? src_q1[0][7:0] : 8'h00;
   endtask

   // One clock: sample at the falling edge, update the model, release at +1.
   task automatic tick();
      logic [8:0] e;
      @(negedge clk);
      model_compare();
      if (vec_on) vec_compare();
      snap_grant = grant;
      snap_ready = req_ready;
      snap_pulse = timeout_pulse;
      snap_txv   = tx_valid;
      xfer_seen  = tx_valid && tx_ready;
      xfer_src   = grant[1];
      xfer_last  = xfer_seen && req_last[xfer_src];
      if (xfer_seen && sb_on) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_byte actual=%0h expected=none", {xfer_src, tx_data});
         end else begin
            e = exp_q.pop_front();
            check("sb_byte", {xfer_src, tx_data}, e);
         end
      end
      if (src_on) begin
         if (req_valid[0] && req_ready[0]) void'(src_q0.pop_front());
         if (req_valid[1] && req_ready[1]) void'(src_q1.pop_front());
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_cycle();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int ncyc;
      int early;
      bit req0_done;
      int p;

      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // rst v l d0 d1 tr | grant tx_valid tx_data req_ready busy timeout
      vecs[0]  = '{1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 2'b01, 2'b00, 8'h48, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 2'b01, 2'b00, 8'h48, 8'h00, 1'b1, 2'b01, 1'b1, 8'h48, 2'b01, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 2'b01, 2'b00, 8'h69, 8'h00, 1'b1, 2'b01, 1'b1, 8'h69, 2'b01, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 2'b01, 2'b01, 8'h0A, 8'h00, 1'b1, 2'b01, 1'b1, 8'h0A, 2'b01, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 2'b11, 2'b11, 8'h11, 8'h22, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 2'b11, 2'b11, 8'h11, 8'h22, 1'b0, 2'b10, 1'b1, 8'h22, 2'b00, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 2'b11, 2'b11, 8'h11, 8'h22, 1'b1, 2'b10, 1'b1, 8'h22, 2'b10, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 2'b11, 2'b11, 8'h11, 8'h22, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 2'b11, 2'b11, 8'h11, 8'h22, 1'b1, 2'b01, 1'b1, 8'h11, 2'b01, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};

      vec_on = 1'b1;
      for (int i = 0; i < NV; i++) begin
         vidx      = i;
         cur       = vecs[i];
         rst       = cur.rst;
         req_valid = cur.v;
         req_last  = cur.l;
         req_data  = {cur.d1, cur.d0};
         tx_ready  = cur.tr;
         tick();
      end
      vec_on = 1'b0;

      // Contention: both hold valid from reset, two 2-byte packets each.
      reset_cycle();
      src_q0 = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3};
      src_q1 = '{9'h0B0, 9'h1B1, 9'h0B2, 9'h1B3};
      exp_q  = '{9'h0A0, 9'h0A1, 9'h1B0, 9'h1B1, 9'h0A2, 9'h0A3, 9'h1B2, 9'h1B3};
      sb_on  = 1'b1;
      src_on = 1'b1;
      tx_ready = 1'b1;
      ncyc = 0;
      while (ncyc < 60 && (src_q0.size() + src_q1.size()) > 0) begin
         drive_src(2'b11);
         tick();
         ncyc++;
      end
      check("contention_drained", src_q0.size() + src_q1.size(), 0);
      check("contention_sb_left", exp_q.size(), 0);
      check("contention_cycles", ncyc, 12);

      // Backpressure: req0 mid-packet while req1 waits with valid high.
      reset_cycle();
      src_q0 = '{9'h010, 9'h011, 9'h012, 9'h113};
      src_q1 = '{9'h020, 9'h121};
      exp_q  = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h120, 9'h121};
      drive_src(2'b01);
      tx_ready = 1'b1;
      tick();
      early     = 0;
      req0_done = 1'b0;
      ncyc      = 0;
      while (ncyc < 60 && (src_q0.size() + src_q1.size()) > 0) begin
         tx_ready = (ncyc % 2 == 0);
         drive_src(2'b11);
         tick();
         if (!req0_done && snap_ready[1]) early++;
         if (xfer_seen && !xfer_src && xfer_last) req0_done = 1'b1;
         ncyc++;
      end
      check("bp_req1_ready_early", early, 0);
      check("bp_req0_done", req0_done, 1'b1);
      check("bp_drained", src_q0.size() + src_q1.size(), 0);
      check("bp_sb_left", exp_q.size(), 0);
      sb_on  = 1'b0;
      src_on = 1'b0;

      // Timeout: req0 sends one byte without last, then goes quiet.
      reset_cycle();
      req_valid = 2'b11;
      req_data  = {8'h77, 8'h55};
      tx_ready  = 1'b1;
      tick();
      tick();
      check("to_first_xfer", {xfer_seen, xfer_src, tx_data}, {1'b1, 1'b0, 8'h55});
      req_valid = 2'b10;
      for (int k = 1; k <= 18; k++) begin
         tick();
         check($sformatf("to_pulse_c%0d", k), snap_pulse, k == 17);
         check($sformatf("to_grant_c%0d", k), snap_grant, (k <= 16) ? 2'b01 : (k == 17) ? 2'b00 : 2'b10);
      end

      // Near-timeout save: 15 stall cycles, then the last byte.
      reset_cycle();
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h31};
      tick();
      tick();
      req_valid = 2'b00;
      for (int k = 1; k <= 15; k++) begin
         tick();
         check($sformatf("near_pulse_c%0d", k), snap_pulse, 1'b0);
      end
      req_valid = 2'b01;
      req_last  = 2'b01;
      req_data  = {8'h00, 8'h32};
      tick();
      check("near_last_xfer", {xfer_seen, xfer_last, snap_pulse}, 3'b110);
      req_valid = 2'b00;
      req_last  = 2'b00;
      tick();
      check("near_release", {snap_grant, snap_pulse}, 3'b000);
      tick();
      check("near_no_late_pulse", snap_pulse, 1'b0);

      // Reset while req1 owns the UART mid-packet.
      reset_cycle();
      req_valid = 2'b10;
      req_data  = {8'h41, 8'h00};
      tick();
      tick();
      check("rst_owner", {snap_grant, xfer_seen}, 3'b101);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      req_valid = 2'b11;
      tick();
      check("rst_after_grant", snap_grant, 2'b00);
      check("rst_after_tx_valid", snap_txv, 1'b0);
      tick();
      check("rst_req0_first", snap_grant, 2'b01);

      // Randomized traffic, alternating dense and sparse phases.
      reset_cycle();
      for (int c = 0; c < 3000; c++) begin
         p         = ((c / 500) % 2 == 0) ? 85 : 10;
         rst       = ($urandom_range(0, 299) == 0);
         req_valid = {($urandom_range(0, 99) < p), ($urandom_range(0, 99) < p)};
         req_last  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         req_data  = 16'($urandom);
         tx_ready  = ($urandom_range(0, 99) < 70);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
